// File: rtl/stage_queue_if.sv
// Valid/ready handshake bundle between a pipeline stage producer, the
// stage_queue buffer and the downstream consumer.
interface stage_queue_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     almost_full;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, almost_full
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, almost_full
  );
endinterface

// File: rtl/stage_queue.sv
// Elastic pipeline-stage FIFO with optional empty-queue bypass, synchronous
// flush and an almost-full threshold; stall is pure back-pressure.
module stage_queue #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 4,
  parameter int BYPASS   = 1,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  stage_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic empty_s, bypass_s, push_s, pop_s, write_s, pop_mem_s;

  // Handshake outputs, bypass steering and next-state pointer/count math
  always_comb begin
    empty_s    = (count_q == {CW{1'b0}});
    q.in_ready = !reset && (count_q < CW'(DEPTH));
    bypass_s   = (BYPASS != 0) && empty_s && q.in_valid && !flush && !reset;

    if (bypass_s) begin
      q.out_valid = 1'b1;
      q.out_data  = q.in_data;
    end else begin
      q.out_valid = !empty_s && !flush && !reset;
      q.out_data  = mem_q[head_q];
    end

    push_s    = q.in_valid && q.in_ready && !flush;
    pop_s     = q.out_valid && q.out_ready;
    // A bypassed word taken by the consumer never touches storage
    write_s   = push_s && !(bypass_s && q.out_ready);
    pop_mem_s = pop_s && !bypass_s;

    if (reset || flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      head_d  = head_q + PW'(pop_mem_s);
      tail_d  = tail_q + PW'(write_s);
      count_d = count_q + CW'(write_s) - CW'(pop_mem_s);
    end

    q.count       = count_q;
    q.almost_full = (count_q >= CW'(AF_LEVEL));
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end

  // Entry storage; contents are deliberately not cleared by reset or flush
  always_ff @(posedge clk) begin
    if (write_s && !reset) begin
      mem_q[tail_q] <= q.in_data;
    end else begin
      mem_q[tail_q] <= mem_q[tail_q];
    end
  end
endmodule
